// File: rtl/sram_resp_pkg.sv
// Shared types and limits for the SRAM-like instruction/data responder.
package sram_resp_pkg;

  localparam int DEPTH_MAX   = 4;
  localparam int LATENCY_MAX = 15;
  localparam int LAT_W       = 4;
  localparam int CNT_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_entry_t;

  localparam int ENTRY_W = $bits(req_entry_t);

endpackage

// File: rtl/sram_req_fifo.sv
// Small synchronous FIFO holding accepted requests; head is the oldest entry.
module sram_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [2**PW];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: only entries counted by count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/inst_sram_responder.sv
// Responder end of the req/addr_ok/data_ok interface: queues requests and
// services them in order against a synchronous RAM with programmable latency.
module inst_sram_responder
  import sram_resp_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sram_req,
  input  logic              sram_wr,
  input  logic [1:0]        sram_size,
  input  logic [3:0]        sram_wstrb,
  input  logic [31:0]       sram_addr,
  input  logic [31:0]       sram_wdata,
  output logic              sram_addr_ok,
  output logic              sram_data_ok,
  output logic [31:0]       sram_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [29:0]       ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output state_t            dbg_state,
  output logic [CNT_W-1:0]  dbg_count
);

  localparam int FCW = $clog2(DEPTH + 1);
  localparam logic [LAT_W-1:0] LAT_INIT = (LATENCY == 0) ? '0 : LAT_W'(LATENCY - 1);
  localparam state_t START_ST = (LATENCY == 0) ? ST_ACCESS : ST_WAIT;

  state_t           state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  req_entry_t       head;
  req_entry_t       push_entry;
  logic             full, empty, push, pop;
  logic [FCW-1:0]   count;
  logic             unused_bits;

  // Acceptance looks only at the registered fill level, never at req or pop.
  assign sram_addr_ok = !reset && !full;
  assign push         = sram_req && sram_addr_ok;
  assign push_entry   = '{wr: sram_wr, size: sram_size, wstrb: sram_wstrb,
                          addr: sram_addr, wdata: sram_wdata};
  assign unused_bits  = ^{head.size, head.addr[1:0]};

  sram_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pop          = 1'b0;
    ram_en       = 1'b0;
    ram_we       = '0;
    ram_addr     = '0;
    ram_wdata    = '0;
    sram_data_ok = 1'b0;
    sram_rdata   = '0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          state_d = START_ST;
          cnt_d   = LAT_INIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_ACCESS;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_ACCESS: begin
        ram_en    = 1'b1;
        ram_we    = head.wr ? head.wstrb : 4'b0000;
        ram_addr  = head.addr[31:2];
        ram_wdata = head.wdata;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        sram_data_ok = 1'b1;
        sram_rdata   = head.wr ? 32'h0 : ram_rdata;
        pop          = 1'b1;
        // Only entries already registered count; a same-cycle push waits in IDLE.
        if (count > FCW'(1)) begin
          state_d = START_ST;
          cnt_d   = LAT_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dbg_state = state_q;
  assign dbg_count = CNT_W'(count);

endmodule

// File: tb/tb_inst_sram_responder.sv
// Bench for inst_sram_responder: three configurations, a shared RAM model,
// a reference memory that predicts every response, and a monitor scoreboard.
module tb_inst_sram_responder;
  import sram_resp_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        req;
  logic              s_wr;
  logic [1:0]        s_size;
  logic [3:0]        s_wstrb;
  logic [31:0]       s_addr;
  logic [31:0]       s_wdata;
  logic [2:0]        addr_ok, data_ok, ram_en;
  logic [31:0]       rdata     [3];
  logic [3:0]        ram_we    [3];
  logic [29:0]       ram_addr  [3];
  logic [31:0]       ram_wdata [3];
  logic [31:0]       ram_rdata = '0;
  state_t            dbg_state [3];
  logic [CNT_W-1:0]  dbg_count [3];

  int sel = 0;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] exp_q[$];
  logic [29:0] exp_addr_q[$];
  int          dok_q[$];
  int          last_en_cyc = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inst_sram_responder #(.DEPTH(2), .LATENCY(1)) u_d2_l1 (
    .clk(clk), .reset(reset), .sram_req(req[0]), .sram_wr(s_wr), .sram_size(s_size),
    .sram_wstrb(s_wstrb), .sram_addr(s_addr), .sram_wdata(s_wdata),
    .sram_addr_ok(addr_ok[0]), .sram_data_ok(data_ok[0]), .sram_rdata(rdata[0]),
    .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
    .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata),
    .dbg_state(dbg_state[0]), .dbg_count(dbg_count[0]));

  inst_sram_responder #(.DEPTH(2), .LATENCY(0)) u_d2_l0 (
    .clk(clk), .reset(reset), .sram_req(req[1]), .sram_wr(s_wr), .sram_size(s_size),
    .sram_wstrb(s_wstrb), .sram_addr(s_addr), .sram_wdata(s_wdata),
    .sram_addr_ok(addr_ok[1]), .sram_data_ok(data_ok[1]), .sram_rdata(rdata[1]),
    .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
    .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata),
    .dbg_state(dbg_state[1]), .dbg_count(dbg_count[1]));

  inst_sram_responder #(.DEPTH(4), .LATENCY(15)) u_d4_l15 (
    .clk(clk), .reset(reset), .sram_req(req[2]), .sram_wr(s_wr), .sram_size(s_size),
    .sram_wstrb(s_wstrb), .sram_addr(s_addr), .sram_wdata(s_wdata),
    .sram_addr_ok(addr_ok[2]), .sram_data_ok(data_ok[2]), .sram_rdata(rdata[2]),
    .ram_en(ram_en[2]), .ram_we(ram_we[2]), .ram_addr(ram_addr[2]),
    .ram_wdata(ram_wdata[2]), .ram_rdata(ram_rdata),
    .dbg_state(dbg_state[2]), .dbg_count(dbg_count[2]));

  // Synchronous backing RAM, served by whichever instance is under test.
  always @(posedge clk) begin
    if (ram_en[sel]) begin
      ram_rdata <= mem[ram_addr[sel][9:0]];
      for (int b = 0; b < 4; b++)
        if (ram_we[sel][b]) mem[ram_addr[sel][9:0]][b*8 +: 8] <= ram_wdata[sel][b*8 +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Reference: requests complete in acceptance order, so memory effects apply at acceptance.
  task automatic model_push(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
    logic [9:0] word;
    word = a[11:2];
    if (w) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[word][b*8 +: 8] = d[b*8 +: 8];
      exp_q.push_back(32'h0);
    end else begin
      exp_q.push_back(ref_mem[word]);
    end
    exp_addr_q.push_back(a[31:2]);
  endtask

  // Called at a negedge; returns at the negedge after the handshake cycle.
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output int t);
    int budget;
    budget  = 0;
    s_wr    = w;
    s_addr  = a;
    s_wdata = d;
    s_wstrb = s;
    s_size  = 2'($urandom_range(0, 3));
    req[sel] = 1'b1;
    while (!addr_ok[sel] && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!addr_ok[sel]) begin
      check("accept_timeout", {31'b0, addr_ok[sel]}, 32'h1);
      t = -1;
    end else begin
      t = cyc;
      model_push(w, a, d, s);
    end
    @(negedge clk);
    req[sel] = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 600) begin
      @(negedge clk);
      budget++;
    end
    check("drain_remaining", exp_q.size(), 32'h0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: scoreboard for data_ok/rdata, access address order, idle RAM outputs.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        if (data_ok[i]) begin
          check("data_ok_expected", {31'b0, (i == sel) && (exp_q.size() > 0)}, 32'h1);
          if (i == sel && exp_q.size() > 0) begin
            check("rdata", rdata[i], exp_q.pop_front());
            dok_q.push_back(cyc);
          end
        end
      end
      if (ram_en[sel]) begin
        last_en_cyc = cyc;
        check("access_expected", {31'b0, exp_addr_q.size() > 0}, 32'h1);
        if (exp_addr_q.size() > 0) check("ram_addr", {2'b0, ram_addr[sel]}, {2'b0, exp_addr_q.pop_front()});
      end else begin
        check("ram_idle_zero", {31'b0, |{ram_we[sel], ram_addr[sel], ram_wdata[sel]}}, 32'h0);
      end
    end
  end

  int t0, t1, t2, t3;
  int budget;

  initial begin
    reset   = 1'b1;
    req     = '0;
    s_wr    = 1'b0;
    s_size  = '0;
    s_wstrb = '0;
    s_addr  = '0;
    s_wdata = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = $urandom();
      ref_mem[i] = mem[i];
    end
    mem[10'h100] = 32'h02800C00; ref_mem[10'h100] = 32'h02800C00;
    mem[10'h002] = 32'h11223344; ref_mem[10'h002] = 32'h11223344;

    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_addr_ok", {31'b0, addr_ok[i]}, 32'h0);
      check("reset_data_ok", {31'b0, data_ok[i]}, 32'h0);
      check("reset_ram_en",  {31'b0, ram_en[i]},  32'h0);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check("addr_ok_after_reset", {31'b0, addr_ok[i]}, 32'h1);

    // Single read with latency 1.
    sel = 0;
    dok_q.delete();
    send(1'b0, 32'h400, 32'h0, 4'h0, t0);
    wait_drain();
    check("single_ram_en_cycle", last_en_cyc, t0 + 3);
    check("single_data_ok_count", dok_q.size(), 32'd1);
    if (dok_q.size() > 0) check("single_data_ok_cycle", dok_q[0], t0 + 4);

    // Byte-masked write then read, and a misaligned read.
    send(1'b1, 32'h8, 32'hAABBCCDD, 4'b0011, t0);
    send(1'b0, 32'h8, 32'h0, 4'h0, t0);
    send(1'b0, 32'h406, 32'h0, 4'h0, t0);
    wait_drain();

    // Fill and drain with zero latency.
    sel = 1;
    dok_q.delete();
    send(1'b0, 32'h10, 32'h0, 4'h0, t0);
    send(1'b0, 32'h14, 32'h0, 4'h0, t1);
    send(1'b0, 32'h18, 32'h0, 4'h0, t2);
    wait_drain();
    check("fill_second_accept", t1, t0 + 1);
    check("fill_third_accept",  t2, t0 + 4);
    check("fill_data_ok_count", dok_q.size(), 32'd3);
    if (dok_q.size() == 3) begin
      check("fill_data_ok_0", dok_q[0], t0 + 3);
      check("fill_data_ok_1", dok_q[1], t0 + 5);
      check("fill_data_ok_2", dok_q[2], t0 + 7);
    end

    // Randomized traffic on both short-latency configurations.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int n = 0; n < 30; n++) begin
        send(1'($urandom_range(0, 1)), {20'h0, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))},
             $urandom(), 4'($urandom_range(0, 15)), t0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_drain();
    end

    // Maximum configuration with continuous requests.
    sel = 2;
    dok_q.delete();
    send(1'b0, 32'h20, 32'h0, 4'h0, t0);
    for (int n = 1; n < 6; n++) send(1'b0, 32'h20 + 32'(4 * n), 32'h0, 4'h0, t3);
    wait_drain();
    check("max_data_ok_count", dok_q.size(), 32'd6);
    if (dok_q.size() == 6) begin
      check("max_first_data_ok", dok_q[0], t0 + 18);
      for (int n = 1; n < 6; n++) check("max_spacing", dok_q[n] - dok_q[n-1], 32'd17);
    end

    // Asynchronous reset while waiting with two requests outstanding.
    send(1'b0, 32'h40, 32'h0, 4'h0, t0);
    send(1'b0, 32'h44, 32'h0, 4'h0, t1);
    budget = 0;
    while (dbg_state[2] != ST_WAIT && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("reached_wait", {30'b0, dbg_state[2]}, {30'b0, ST_WAIT});
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_addr_ok", {31'b0, addr_ok[2]}, 32'h0);
    check("midreset_ram_en",  {31'b0, ram_en[2]},  32'h0);
    check("midreset_ram_out", {31'b0, |{ram_we[2], ram_addr[2], ram_wdata[2]}}, 32'h0);
    check("midreset_count",   {29'b0, dbg_count[2]}, 32'h0);
    exp_q.delete();
    exp_addr_q.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_reset_addr_ok", {31'b0, addr_ok[2]}, 32'h1);
    check("post_reset_state", {30'b0, dbg_state[2]}, {30'b0, ST_IDLE});
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
